ball_engine: RTL and testbench
==============================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter SCREEN_X, default 640: horizontal screen size in pixels.
REQ-002 Parameter SCREEN_Y, default 480: vertical screen size in pixels.
REQ-003 Parameter WIDTH, default 6: ball width in pixels.
REQ-004 Parameter HEIGHT, default 6: ball height in pixels.
REQ-005 Parameter TICK_DIV, default 15, range 1..65535: clock cycles per motion tick.
REQ-006 Parameter SPEED_MAX, default 4, range 1..7: maximum step size, in pixels per tick per axis.
REQ-007 Parameter SERVE_TICKS, default 60: motion ticks spent waiting before a serve.
REQ-008 Parameter COLOR, default 3'b111: ball pixel colour.
REQ-009 clock  in  1  sole clock; all state updates on its rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 row  in  10  queried pixel row.
REQ-012 col  in  10  queried pixel column.
REQ-013 bounce  in  2  event code: 00 none, 01 paddle hit, 10 wall hit, 11 score.
REQ-014 rgb  out  3  colour of the queried pixel.
REQ-015 pos_x  out  10  left edge of the ball.
REQ-016 pos_y  out  10  top edge of the ball.
REQ-017 size_x  out  8  equals WIDTH.
REQ-018 size_y  out  8  equals HEIGHT.
REQ-019 speed  out  3  current step size.
REQ-020 serving  out  1  high while in SERVE_WAIT.

Function
REQ-021 Tick: a divider counts 0..TICK_DIV-1 and asserts tick for one cycle when the count wraps.
REQ-022 Event capture: a nonzero bounce is latched into a pending register in any cycle.
  - Priority on overwrite: score > paddle > wall.
  - The pending event is consumed and cleared on the next tick.
  - An event arriving in the same cycle as the tick is consumed on that tick.
REQ-023 FSM states: SERVE_WAIT and MOVING.
REQ-024 SERVE_WAIT: a serve counter increments each tick.
  - At SERVE_TICKS-1 the FSM moves to MOVING.
  - Position is held during SERVE_WAIT.
  - Pending paddle and wall events are discarded.
REQ-025 MOVING, score event on a tick:
  - position set to centre: pos_x = (SCREEN_X-WIDTH)/2, pos_y = (SCREEN_Y-HEIGHT)/2.
  - speed set to 1, dir_x inverted, dir_y unchanged.
  - serve counter cleared; FSM enters SERVE_WAIT.
  - no motion is applied on that tick.
REQ-026 MOVING, paddle event on a tick:
  - dir_x inverted.
  - speed incremented, saturating at SPEED_MAX.
  - motion is then applied with the new direction and speed.
REQ-027 MOVING, wall event on a tick: dir_y inverted, then motion applied.
REQ-028 Motion: pos_x moves by ±speed according to dir_x; pos_y moves by ±speed according to dir_y.
  - Arithmetic uses 11-bit signed intermediates.
REQ-029 X boundary: clamp pos_x to 0..SCREEN_X-WIDTH; dir_x is not changed (goals are scored externally).
REQ-030 Y boundary: if the computed pos_y falls outside 0..SCREEN_Y-HEIGHT, clamp it and invert dir_y on that tick.
REQ-031 rgb is combinational with zero latency.
  - rgb = COLOR when pos_x <= col < pos_x+WIDTH and pos_y <= row < pos_y+HEIGHT.
  - rgb = 3'b000 otherwise.

Reset
REQ-032 Reset mid-operation takes effect immediately, with no clock edge needed.
REQ-033 Reset values:
  - state SERVE_WAIT; divider, serve counter and pending event cleared.
  - pos at centre; speed 1; dir_x +1 (right); dir_y +1 (down).
  - serving 1; size outputs WIDTH/HEIGHT.

Structure
REQ-034 The bounce codes, state encodings and screen-size defaults shall live in the shared include pong_defs.vh.
REQ-035 The tick generator shall be the sub-module tick_divider, parametrised by TICK_DIV.
  - Its outputs are tick and a count.

Verification
REQ-036 Release reset with TICK_DIV=2 and SERVE_TICKS=3 -> serving drops after 6 cycles; next tick pos=(318,238).
REQ-037 In MOVING at speed 1, pulse bounce=01 once -> dir_x flips, speed=2, pos_x decreases by 2 on the consuming tick.
REQ-038 Apply 3+ paddle hits with SPEED_MAX=2 -> speed saturates at 2.
REQ-039 Ball at pos_y=473 moving down at speed 3 -> pos_y clamps to 474 and dir_y inverts.
REQ-040 Pulse wall (10) then score (11) within one tick period -> score wins: centre, speed 1, serving=1.
REQ-041 Assert reset asynchronously mid-tick -> outputs reach reset values before the next clock edge.
  - Query row=240, col=320 after reset -> rgb=111.

Source files
------------

// File: rtl/ball_engine_pkg.sv
// rtl/ball_engine_pkg.sv - shared bounce codes, FSM encodings and screen defaults
package ball_engine_pkg;

    localparam logic [1:0] BOUNCE_NONE   = 2'b00;
    localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0] BOUNCE_WALL   = 2'b10;
    localparam logic [1:0] BOUNCE_SCORE  = 2'b11;

    localparam logic [0:0] ST_SERVE_WAIT = 1'b0;
    localparam logic [0:0] ST_MOVING     = 1'b1;

    localparam int DEF_SCREEN_X = 640;
    localparam int DEF_SCREEN_Y = 480;

    // Combine two event codes keeping the most important one: score > paddle > wall.
    function automatic logic [1:0] merge_bounce(input logic [1:0] a, input logic [1:0] b);
        if (a == BOUNCE_SCORE || b == BOUNCE_SCORE) return BOUNCE_SCORE;
        if (a == BOUNCE_PADDLE || b == BOUNCE_PADDLE) return BOUNCE_PADDLE;
        if (a == BOUNCE_WALL || b == BOUNCE_WALL) return BOUNCE_WALL;
        return BOUNCE_NONE;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle motion tick
module tick_divider #(
    parameter int TICK_DIV = 15
) (
    input  logic        clock,
    input  logic        reset,
    output logic        tick,
    output logic [15:0] count
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q + 16'd1;
        if (count_q == LAST) count_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign tick  = (count_q == LAST);
    assign count = count_q;

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - pong ball: serve timing, bounce handling, motion and pixel query
module ball_engine
    import ball_engine_pkg::*;
#(
    parameter int         SCREEN_X    = DEF_SCREEN_X,
    parameter int         SCREEN_Y    = DEF_SCREEN_Y,
    parameter int         WIDTH       = 6,
    parameter int         HEIGHT      = 6,
    parameter int         TICK_DIV    = 15,
    parameter int         SPEED_MAX   = 4,
    parameter int         SERVE_TICKS = 60,
    parameter logic [2:0] COLOR       = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic [1:0] bounce,
    output logic [2:0] rgb,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [7:0] size_x,
    output logic [7:0] size_y,
    output logic [2:0] speed,
    output logic       serving
);

    localparam logic [9:0]         CTR_X      = 10'((SCREEN_X - WIDTH) / 2);
    localparam logic [9:0]         CTR_Y      = 10'((SCREEN_Y - HEIGHT) / 2);
    localparam logic signed [10:0] LIM_X      = 11'(SCREEN_X - WIDTH);
    localparam logic signed [10:0] LIM_Y      = 11'(SCREEN_Y - HEIGHT);
    localparam logic [2:0]         SPD_MAX    = 3'(SPEED_MAX);
    localparam logic [15:0]        SERVE_LAST = 16'(SERVE_TICKS - 1);

    logic        tick;
    logic [15:0] div_count;
    logic        div_unused;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .count (div_count)
    );

    assign div_unused = ^div_count;

    logic [0:0]  state_q, state_d;
    logic [15:0] serve_q, serve_d;
    logic [1:0]  pend_q, pend_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic [2:0]  speed_q, speed_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;

    logic [1:0]         evt;
    logic [2:0]         spd;
    logic               dx, dy;
    logic signed [10:0] step, nx, ny;

    always_comb begin
        evt     = merge_bounce(pend_q, bounce);
        state_d = state_q;
        serve_d = serve_q;
        pend_d  = tick ? BOUNCE_NONE : evt;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        speed_d = speed_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        spd     = speed_q;
        dx      = dir_x_q;
        dy      = dir_y_q;
        step    = '0;
        nx      = '0;
        ny      = '0;
        if (tick) begin
            if (state_q == ST_SERVE_WAIT) begin
                // Any event seen while waiting to serve is dropped.
                if (serve_q == SERVE_LAST) begin
                    state_d = ST_MOVING;
                    serve_d = '0;
                end else begin
                    serve_d = serve_q + 16'd1;
                end
            end else if (evt == BOUNCE_SCORE) begin
                pos_x_d = CTR_X;
                pos_y_d = CTR_Y;
                speed_d = 3'd1;
                dir_x_d = ~dir_x_q;
                serve_d = '0;
                state_d = ST_SERVE_WAIT;
            end else begin
                if (evt == BOUNCE_PADDLE) begin
                    dx = ~dir_x_q;
                    if (speed_q < SPD_MAX) spd = speed_q + 3'd1;
                end
                if (evt == BOUNCE_WALL) dy = ~dir_y_q;
                step = $signed({8'd0, spd});
                nx   = dx ? $signed({1'b0, pos_x_q}) + step : $signed({1'b0, pos_x_q}) - step;
                ny   = dy ? $signed({1'b0, pos_y_q}) + step : $signed({1'b0, pos_y_q}) - step;
                // X is only clamped; goals beyond the edge are judged outside this block.
                if (nx < 11'sd0)       pos_x_d = '0;
                else if (nx > LIM_X)   pos_x_d = LIM_X[9:0];
                else                   pos_x_d = nx[9:0];
                if (ny < 11'sd0) begin
                    pos_y_d = '0;
                    dy      = ~dy;
                end else if (ny > LIM_Y) begin
                    pos_y_d = LIM_Y[9:0];
                    dy      = ~dy;
                end else begin
                    pos_y_d = ny[9:0];
                end
                speed_d = spd;
                dir_x_d = dx;
                dir_y_d = dy;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_SERVE_WAIT;
            serve_q <= '0;
            pend_q  <= BOUNCE_NONE;
            pos_x_q <= CTR_X;
            pos_y_q <= CTR_Y;
            speed_q <= 3'd1;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            state_q <= state_d;
            serve_q <= serve_d;
            pend_q  <= pend_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            speed_q <= speed_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    logic in_x, in_y;

    assign in_x = ({1'b0, col} >= {1'b0, pos_x_q}) && ({1'b0, col} < {1'b0, pos_x_q} + 11'(WIDTH));
    assign in_y = ({1'b0, row} >= {1'b0, pos_y_q}) && ({1'b0, row} < {1'b0, pos_y_q} + 11'(HEIGHT));

    assign rgb     = (in_x && in_y) ? COLOR : 3'b000;
    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign size_x  = 8'(WIDTH);
    assign size_y  = 8'(HEIGHT);
    assign speed   = speed_q;
    assign serving = (state_q == ST_SERVE_WAIT);

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - directed self-checking bench for ball_engine
module tb_ball_engine;

    logic       clock = 1'b0;
    logic       reset_a = 1'b1, reset_b = 1'b1;
    logic [9:0] row = 10'd240, col = 10'd320;
    logic [1:0] bounce_a = 2'b00, bounce_b = 2'b00;

    logic [2:0] rgb_a, rgb_b, speed_a, speed_b;
    logic [9:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;
    logic [7:0] size_x_a, size_y_a, size_x_b, size_y_b;
    logic       serving_a, serving_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ball_engine #(.TICK_DIV(2), .SERVE_TICKS(3), .SPEED_MAX(2)) dut_a (
        .clock(clock), .reset(reset_a), .row(row), .col(col), .bounce(bounce_a),
        .rgb(rgb_a), .pos_x(pos_x_a), .pos_y(pos_y_a), .size_x(size_x_a),
        .size_y(size_y_a), .speed(speed_a), .serving(serving_a)
    );

    ball_engine #(.TICK_DIV(2), .SERVE_TICKS(3), .SPEED_MAX(3)) dut_b (
        .clock(clock), .reset(reset_b), .row(row), .col(col), .bounce(bounce_b),
        .rgb(rgb_b), .pos_x(pos_x_b), .pos_y(pos_y_b), .size_x(size_x_b),
        .size_y(size_y_b), .speed(speed_b), .serving(serving_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) next_edge();
    endtask

    task automatic check_a(input string tag, input int x, input int y, input int s);
        check({tag, "_x"}, int'(pos_x_a), x);
        check({tag, "_y"}, int'(pos_y_a), y);
        check({tag, "_speed"}, int'(speed_a), s);
    endtask

    initial begin
        edges(3);
        check_a("rst", 317, 237, 1);
        check("rst_serving", int'(serving_a), 1);
        check("rst_size_x", int'(size_x_a), 6);
        check("rst_size_y", int'(size_y_a), 6);
        check("rgb_centre", int'(rgb_a), 7);
        col = 10'd317; #1 check("rgb_left_in", int'(rgb_a), 7);
        col = 10'd316; #1 check("rgb_left_out", int'(rgb_a), 0);
        col = 10'd322; #1 check("rgb_right_in", int'(rgb_a), 7);
        col = 10'd323; #1 check("rgb_right_out", int'(rgb_a), 0);
        col = 10'd320; row = 10'd242; #1 check("rgb_bottom_in", int'(rgb_a), 7);
        row = 10'd243; #1 check("rgb_bottom_out", int'(rgb_a), 0);
        row = 10'd240;

        next_edge();
        reset_a = 1'b0;
        edges(5);
        check("serve_e5", int'(serving_a), 1);
        next_edge();
        check("serve_e6", int'(serving_a), 0);
        check_a("serve_hold", 317, 237, 1);
        edges(2);
        check_a("first_move", 318, 238, 1);

        bounce_a = 2'b01; next_edge(); bounce_a = 2'b00; next_edge();
        check_a("paddle1", 316, 240, 2);
        bounce_a = 2'b01; next_edge(); bounce_a = 2'b00; next_edge();
        check_a("paddle2_sat", 318, 242, 2);
        bounce_a = 2'b01; next_edge(); bounce_a = 2'b00; next_edge();
        check_a("paddle3_sat", 316, 244, 2);
        next_edge();
        bounce_a = 2'b01; next_edge(); bounce_a = 2'b00;
        check_a("paddle_same_cycle", 318, 246, 2);

        bounce_a = 2'b10; next_edge();
        bounce_a = 2'b11; next_edge(); bounce_a = 2'b00;
        check_a("score_wins", 317, 237, 1);
        check("score_serving", int'(serving_a), 1);
        edges(6);
        check("reserve_done", int'(serving_a), 0);
        edges(2);
        check_a("after_serve", 316, 238, 1);

        bounce_a = 2'b10; next_edge(); bounce_a = 2'b00; next_edge();
        check_a("wall", 315, 237, 1);

        next_edge();
        #2 reset_a = 1'b1;
        #1;
        check_a("async_rst", 317, 237, 1);
        check("async_rst_serving", int'(serving_a), 1);
        check("async_rst_rgb", int'(rgb_a), 7);

        next_edge();
        reset_b = 1'b0;
        edges(6);
        check("b_serve_done", int'(serving_b), 0);
        bounce_b = 2'b01; next_edge(); bounce_b = 2'b00; next_edge();
        check("b_p1_x", int'(pos_x_b), 315);
        check("b_p1_y", int'(pos_y_b), 239);
        check("b_p1_speed", int'(speed_b), 2);
        bounce_b = 2'b01; next_edge(); bounce_b = 2'b00; next_edge();
        check("b_p2_x", int'(pos_x_b), 318);
        check("b_p2_y", int'(pos_y_b), 242);
        check("b_p2_speed", int'(speed_b), 3);
        edges(154);
        check("b_pre_clamp_y", int'(pos_y_b), 473);
        check("b_pre_clamp_x", int'(pos_x_b), 549);
        edges(2);
        check("b_clamp_y", int'(pos_y_b), 474);
        edges(2);
        check("b_bounced_y", int'(pos_y_b), 471);
        check("b_bounced_x", int'(pos_x_b), 555);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
